// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} and holds a stall request until the result is ready.
module div #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  input  logic                  start,
  input  logic                  annul,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stallreq
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] S_FREE    = 2'd0;
  localparam logic [1:0] S_BY_ZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dsr;
  logic [DATA_W-1:0] prem;
  logic              q_neg;
  logic              r_neg;

  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  assign stallreq = start & ~ready;

  always_comb begin
    mag1    = (signed_div & opdata1[DATA_W-1]) ? (~opdata1 + 1'b1) : opdata1;
    mag2    = (signed_div & opdata2[DATA_W-1]) ? (~opdata2 + 1'b1) : opdata2;
    // dvd is shifted out at the top while quotient bits enter at the bottom
    shifted = {prem, dvd[DATA_W-1]};
    diff    = shifted - {1'b0, dsr};
    q_fix   = q_neg ? (~dvd + 1'b1) : dvd;
    r_fix   = r_neg ? (~prem + 1'b1) : prem;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_FREE;
      cnt    <= '0;
      dvd    <= '0;
      dsr    <= '0;
      prem   <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          if (start && !annul) begin
            if (opdata2 == '0) begin
              state <= S_BY_ZERO;
            end else begin
              state <= S_ON;
              dvd   <= mag1;
              dsr   <= mag2;
              q_neg <= signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
              r_neg <= signed_div & opdata1[DATA_W-1];
              prem  <= '0;
              cnt   <= '0;
            end
          end
        end
        S_BY_ZERO: begin
          state  <= S_END;
          result <= '0;
          ready  <= 1'b1;
        end
        S_ON: begin
          if (annul) begin
            state  <= S_FREE;
            cnt    <= '0;
            result <= '0;
            ready  <= 1'b0;
          end else if (cnt != CNT_W'(DATA_W)) begin
            prem <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
            dvd  <= {dvd[DATA_W-2:0], ~diff[DATA_W]};
            cnt  <= cnt + 1'b1;
          end else begin
            result <= {r_fix, q_fix};
            ready  <= 1'b1;
            state  <= S_END;
          end
        end
        default: begin
          // Result stays up until EX drops start, so no restart without a gap
          if (!start || annul) begin
            state  <= S_FREE;
            result <= '0;
            ready  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int n_cmp  = 0;
  int n_fail = 0;

  div #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .start      (start),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stallreq   (stallreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Truncating division with remainder taking the dividend's sign; 64-bit
  // intermediates let MIN/-1 wrap naturally once truncated to 32 bits.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a negedge with start already high and operands applied.
  task automatic check_op(input logic [63:0] exp, input int lat);
    int edges;
    int stall_n;
    edges = 0;
    stall_n = 0;
    #1;
    while (ready !== 1'b1 && edges < 200) begin
      if (stallreq === 1'b1) stall_n++;
      @(negedge clk);
      edges++;
    end
    chk("ready_rise", 64'(ready), 64'd1);
    chk("latency", 64'(edges), 64'(lat));
    chk("stall_cycles", 64'(stall_n), 64'(lat));
    chk("result", result, exp);
    @(negedge clk);
    chk("hold_result", result, exp);
    chk("hold_ready", 64'(ready), 64'd1);
    start = 1'b0;
    #1;
    chk("stall_low", 64'(stallreq), 64'd0);
    @(negedge clk);
    chk("ready_fall", 64'(ready), 64'd0);
    chk("result_clear", result, 64'd0);
  endtask

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div = sgn;
    opdata1 = a;
    opdata2 = b;
    start = 1'b1;
    check_op(model(sgn, a, b), (b == 32'd0) ? 2 : 34);
  endtask

  initial begin
    logic        seen_ready;
    logic [31:0] a;
    logic [31:0] b;

    // Reset state
    #1;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed corner cases
    run_op(1'b0, 32'd100, 32'd7);
    chk("model_100_7", model(1'b0, 32'd100, 32'd7), {32'h2, 32'hE});
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
    run_op(1'b0, 32'h1234_5678, 32'h0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h1);
    run_op(1'b1, 32'h8000_0000, 32'h0000_0001);
    run_op(1'b0, 32'h0000_0005, 32'hFFFF_FFFF);

    // Annul at edge 10 of an operation
    @(negedge clk);
    signed_div = 1'b0;
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start = 1'b1;
    seen_ready = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (ready === 1'b1) seen_ready = 1'b1;
    end
    annul = 1'b1;
    @(negedge clk);
    chk("annul_ready", 64'(ready | seen_ready), 64'd0);
    chk("annul_result", result, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ready === 1'b1) seen_ready = 1'b1;
    end
    chk("annul_no_ready", 64'(seen_ready), 64'd0);
    run_op(1'b0, 32'd9, 32'd3);

    // Asynchronous reset at edge 20 of an operation
    @(negedge clk);
    signed_div = 1'b1;
    opdata1 = 32'hFFFF_FC18;
    opdata2 = 32'd7;
    start = 1'b1;
    repeat (19) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_result", result, 64'd0);
    chk("async_rst_ready", 64'(ready), 64'd0);
    opdata1 = 32'd1000;
    opdata2 = 32'd10;
    signed_div = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_op(model(1'b0, 32'd1000, 32'd10), 34);

    // Random operands against the reference model
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 15));
        1: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      run_op(1'($urandom_range(0, 1)), a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle radix-2 restoring divider for the EX stage. Serves DIV/DIVU.
- Accepts a start request from EX and produces {remainder, quotient} for the HI/LO write-back path.
- Raises a stall request while busy. This request feeds the pipeline controller's EX stall input, which freezes PC, IF/ID, ID/EX and EX until the result is ready.

Parameters:
- DATA_W, 32, operand width. Also the iteration count. Result width is 2*DATA_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU). Sampled at accept.
- opdata1  input  DATA_W  dividend. Sampled at accept.
- opdata2  input  DATA_W  divisor. Sampled at accept.
- start  input  1  division request from EX. Held high by EX until ready is seen.
- annul  input  1  abort request (exception/flush). Wins over start.
- result  output  2*DATA_W  {remainder, quotient}. Upper half goes to HI, lower half to LO.
- ready  output  1  result valid.
- stallreq  output  1  combinational: start & ~ready. Goes to the controller's EX stall request.

Behaviour:
- Reset (rst=0, async):
  - state=FREE, counter=0, working registers=0.
  - result=0, ready=0, stallreq follows its formula (0 once start=0).
- Reset mid-operation aborts immediately. No partial result is ever presented.
- States: FREE, BY_ZERO, ON, END.
- FREE, ready=0, result=0:
  - start=1, annul=0, opdata2==0 -> BY_ZERO.
  - start=1, annul=0, opdata2!=0 -> ON. Latch:
    - dividend magnitude: two's-complement abs if signed_div & msb.
    - divisor magnitude: same rule.
    - quotient sign = signed_div & (op1 msb ^ op2 msb).
    - remainder sign = signed_div & op1 msb.
    - partial remainder=0, counter=0.
  - Otherwise stay in FREE.
- BY_ZERO: next edge -> END with result=0. No trap is raised; architecturally undefined, fixed to 0 here.
- ON, one iteration per edge while counter<DATA_W:
  - Shift {partial remainder, dividend} left 1.
  - Trial-subtract the divisor from the upper DATA_W+1 bits.
  - If non-negative: keep the difference and shift in quotient bit 1; else shift in 0.
  - counter++.
- ON, edge with counter==DATA_W:
  - Apply sign fix-ups: negate quotient and/or remainder per the latched signs.
  - Load result, set ready=1, go to END.
- ON with annul=1 at any edge -> FREE, ready=0, result=0, counter=0. Takes priority over the iteration.
- ON with start dropping without annul: ignored. The operation runs to END.
- END, ready=1, result held stable:
  - start=0 or annul=1 -> FREE, ready=0, result=0 on the next edge.
  - start=1 -> hold END. No restart without start first dropping.
- Latency, counting the accepting edge as edge 1:
  - Nonzero divisor: ready=1 after edge DATA_W+2 (34 for DATA_W=32). stallreq is high exactly DATA_W+2 cycles.
  - Zero divisor: ready=1 after edge 2. stallreq is high 2 cycles.
- Arithmetic rules:
  - Remainder sign follows the dividend.
  - Quotient truncates toward zero.
  - Signed MIN/-1 yields quotient 0x80000000, remainder 0, by natural wrap. No overflow flag.
- Back-to-back operations:
  - A new start is accepted only in FREE.
  - Minimum gap is one cycle of start=0 after ready.

Test Plan:
- Unsigned 100/7, start held -> after edge 34: ready=1, result={0x00000002, 0x0000000E}. stallreq high 34 cycles, then 0.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> result={0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- Divisor 0, dividend 0x12345678 -> ready=1 after edge 2, result=0. stallreq high 2 cycles.
- Signed 0x80000000/0xFFFFFFFF -> result={0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF/1 -> {0x0, 0xFFFFFFFF}.
- Start 100/7, assert annul at edge 10 -> FREE next edge, ready never asserts. A new start 9/3 afterwards -> {0x0, 0x3} with full latency.
- Pull rst low at edge 20 of an operation -> result=0, ready=0 immediately, asynchronously. After release with start=1, a fresh operation starts cleanly.
